// File: rtl/enc8b10b_pkg.sv
// Shared types, constants and helpers for the lane 8b10b encoder/decoder stages.
package enc8b10b_pkg;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    typedef struct packed {
        logic [9:0] code;
        logic       kerr;
        logic       derr;
    } symbol_t;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/enc8b10b_rd_sel_if.sv
// Upstream, ROM and serializer signals of the RD-select stage.
// Optional error counters are present when ENC8B10B_ERR_CNT_EN is defined.
interface enc8b10b_rd_sel_if;
    logic [7:0] i_data;
    logic       i_k;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_rom_addr;
    logic       o_rom_rd_en;
    logic       o_rom_k;
    logic [9:0] i_rdp_code;
    logic [9:0] i_rdm_code;
    logic       i_rdp_kerr;
    logic       i_rdm_kerr;
    logic [9:0] o_code;
    logic       o_k_error;
    logic       o_disp_error;
    logic       o_valid;
    logic       i_ready;
    logic       o_rd;
`ifdef ENC8B10B_ERR_CNT_EN
    logic        i_cnt_clr;
    logic [15:0] o_kerr_cnt;
    logic [15:0] o_derr_cnt;
`endif

    modport slave (
        input  i_data, i_k, i_valid, i_rdp_code, i_rdm_code, i_rdp_kerr, i_rdm_kerr, i_ready,
        output o_ready, o_rom_addr, o_rom_rd_en, o_rom_k, o_code, o_k_error, o_disp_error,
        output o_valid, o_rd
`ifdef ENC8B10B_ERR_CNT_EN
        , input i_cnt_clr, output o_kerr_cnt, output o_derr_cnt
`endif
    );

    modport master (
        output i_data, i_k, i_valid, i_rdp_code, i_rdm_code, i_rdp_kerr, i_rdm_kerr, i_ready,
        input  o_ready, o_rom_addr, o_rom_rd_en, o_rom_k, o_code, o_k_error, o_disp_error,
        input  o_valid, o_rd
`ifdef ENC8B10B_ERR_CNT_EN
        , output i_cnt_clr, input o_kerr_cnt, input o_derr_cnt
`endif
    );

endinterface

// File: rtl/enc8b10b_skid_fifo.sv
// Two-entry FIFO used as the skid buffer on both encoder and decoder stages.
module enc8b10b_skid_fifo #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         do_push_s;
    logic         do_pop_s;

    assign do_push_s = push & (count_r != 2'd2);
    assign do_pop_s  = pop & (count_r != 2'd0);

    // Storage, pointers and occupancy; contents cleared so outputs read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r <= wr_ptr_r ^ do_push_s;
            rd_ptr_r <= rd_ptr_r ^ do_pop_s;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/enc8b10b_rd_sel.sv
// Running-disparity select stage: drives the RD+/RD- code ROMs, picks a codeword,
// tracks RD and skid-buffers the result. ENC8B10B_ERR_CNT_EN adds error counters.
module enc8b10b_rd_sel
    import enc8b10b_pkg::*;
#(
    parameter logic RD_INIT    = 1'b0,
    parameter int   SKID_DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    enc8b10b_rd_sel_if.slave bus
);

    logic       inflight_r;
    logic       rd_r;
    logic       ready_s;
    logic       accept_s;
    logic       valid_s;
    logic       pop_s;
    logic [9:0] sel_code_s;
    logic       kerr_s;
    logic       derr_s;
    logic       rd_next_s;
    logic [3:0] ones_s;
    logic [1:0] count_s;
    symbol_t    push_sym_s;
    symbol_t    head_sym_s;

    // A read in flight always owns a free buffer entry, so credit counts it too.
    assign ready_s  = ({1'b0, count_s} + {2'b00, inflight_r}) < 3'(SKID_DEPTH);
    assign accept_s = bus.i_valid & ready_s;

    assign bus.o_ready     = ready_s;
    assign bus.o_rom_addr  = bus.i_data;
    assign bus.o_rom_k     = bus.i_k;
    assign bus.o_rom_rd_en = accept_s;

    // Codeword selection by current RD and disparity bookkeeping of the selected code.
    always_comb begin
        sel_code_s = bus.i_rdm_code;
        kerr_s     = bus.i_rdm_kerr;
        if (rd_r == RD_POS) begin
            sel_code_s = bus.i_rdp_code;
            kerr_s     = bus.i_rdp_kerr;
        end else begin
            sel_code_s = bus.i_rdm_code;
            kerr_s     = bus.i_rdm_kerr;
        end
        ones_s    = popcount10(sel_code_s);
        rd_next_s = rd_r;
        derr_s    = 1'b0;
        case (ones_s)
            4'd5: begin
                rd_next_s = rd_r;
            end
            4'd6: begin
                if (rd_r == RD_NEG) begin
                    rd_next_s = RD_POS;
                end else begin
                    derr_s = 1'b1;
                end
            end
            4'd4: begin
                if (rd_r == RD_POS) begin
                    rd_next_s = RD_NEG;
                end else begin
                    derr_s = 1'b1;
                end
            end
            default: derr_s = 1'b1;
        endcase
    end

    // ROM read tracking and running disparity register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_r <= 1'b0;
            rd_r       <= RD_INIT;
        end else begin
            inflight_r <= accept_s;
            if (inflight_r) begin
                rd_r <= rd_next_s;
            end else begin
                rd_r <= rd_r;
            end
        end
    end

    assign push_sym_s = '{code: sel_code_s, kerr: kerr_s, derr: derr_s};
    assign valid_s    = (count_s != 2'd0);
    assign pop_s      = valid_s & bus.i_ready;

    enc8b10b_skid_fifo #(.W($bits(symbol_t))) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_r),
        .push_data(push_sym_s),
        .pop      (pop_s),
        .head     (head_sym_s),
        .count    (count_s)
    );

    assign bus.o_code       = head_sym_s.code;
    assign bus.o_k_error    = head_sym_s.kerr;
    assign bus.o_disp_error = head_sym_s.derr;
    assign bus.o_valid      = valid_s;
    assign bus.o_rd         = rd_r;

`ifdef ENC8B10B_ERR_CNT_EN
    logic [15:0] kerr_cnt_r;
    logic [15:0] derr_cnt_r;

    // Saturating error counters; a clear request beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kerr_cnt_r <= 16'h0000;
            derr_cnt_r <= 16'h0000;
        end else if (bus.i_cnt_clr) begin
            kerr_cnt_r <= 16'h0000;
            derr_cnt_r <= 16'h0000;
        end else begin
            if (inflight_r && kerr_s && (kerr_cnt_r != 16'hFFFF)) begin
                kerr_cnt_r <= kerr_cnt_r + 16'h0001;
            end
            if (inflight_r && derr_s && (derr_cnt_r != 16'hFFFF)) begin
                derr_cnt_r <= derr_cnt_r + 16'h0001;
            end
        end
    end

    assign bus.o_kerr_cnt = kerr_cnt_r;
    assign bus.o_derr_cnt = derr_cnt_r;
`endif

endmodule

// File: tb/tb_enc8b10b_rd_sel.sv
// Bench for enc8b10b_rd_sel: directed steps, a small ROM model and an in-order scoreboard.
module tb_enc8b10b_rd_sel;
    import enc8b10b_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [11:0] sb[$];
    logic        model_rd = 1'b0;
    logic [7:0]  rom_a = 8'h00;
    logic        rom_kq = 1'b0;
    logic        held = 1'b0;
    logic [11:0] held_val = 12'h000;
    logic [8:0]  stream [6] = '{9'h000, 9'h0B5, 9'h1BC, 9'h04A, 9'h000, 9'h0B5};

    enc8b10b_rd_sel_if bus_if ();

    enc8b10b_rd_sel #(.RD_INIT(1'b0), .SKID_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // External ROM model: returns {rdp_code, rdp_kerr, rdm_code, rdm_kerr}.
    function automatic logic [21:0] rom(input logic [7:0] a, input logic k);
        case ({k, a})
            9'h1BC:  rom = {10'b1100000101, 1'b0, 10'b0011111010, 1'b0};
            9'h0B5:  rom = {10'b1010101010, 1'b0, 10'b1010101010, 1'b0};
            9'h000:  rom = {10'b0110001011, 1'b0, 10'b1001110100, 1'b0};
            9'h04A:  rom = {10'b0101010101, 1'b0, 10'b0101010101, 1'b0};
            9'h100:  rom = {10'b1100001011, 1'b1, 10'b0011110100, 1'b1};
            9'h0FF:  rom = {10'b1111110000, 1'b0, 10'b1111110000, 1'b0};
            default: rom = {10'b0000000000, 1'b0, 10'b0000000000, 1'b0};
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus_if.o_rom_rd_en) begin
            rom_a  <= bus_if.o_rom_addr;
            rom_kq <= bus_if.o_rom_k;
        end
    end

    always_comb begin
        logic [21:0] r;
        r = rom(rom_a, rom_kq);
        bus_if.i_rdp_code = r[21:12];
        bus_if.i_rdp_kerr = r[11];
        bus_if.i_rdm_code = r[10:1];
        bus_if.i_rdm_kerr = r[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push on accept, pop and compare on output handshake, hold-stability check.
    always @(negedge clk) begin
        logic [21:0] r;
        logic [9:0]  sel;
        logic        kerr;
        logic        derr;
        int          ones;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && bus_if.o_valid) begin
                chk("hold_stable", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, held_val);
            end
            held     = bus_if.o_valid & ~bus_if.i_ready;
            held_val = {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error};
            if (bus_if.o_valid && bus_if.i_ready) begin
                chk("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("symbol", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, sb.pop_front());
                end
            end
            chk("rom_rd_en", bus_if.o_rom_rd_en, bus_if.i_valid & bus_if.o_ready);
            if (bus_if.i_valid) begin
                chk("rom_addr", {bus_if.o_rom_k, bus_if.o_rom_addr}, {bus_if.i_k, bus_if.i_data});
            end
            if (bus_if.i_valid && bus_if.o_ready) begin
                r    = rom(bus_if.i_data, bus_if.i_k);
                sel  = model_rd ? r[21:12] : r[10:1];
                kerr = model_rd ? r[11] : r[0];
                ones = $countones(sel);
                derr = 1'b0;
                if (ones == 5) begin
                    derr = 1'b0;
                end else if (ones == 6 && !model_rd) begin
                    model_rd = 1'b1;
                end else if (ones == 4 && model_rd) begin
                    model_rd = 1'b0;
                end else begin
                    derr = 1'b1;
                end
                sb.push_back({sel, kerr, derr});
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus_if.o_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(tag, bus_if.o_ready, 1);
    endtask

    task automatic drive_one(input logic [7:0] d, input logic k);
        @(posedge clk); #1;
        bus_if.i_data  = d;
        bus_if.i_k     = k;
        bus_if.i_valid = 1'b1;
        wait_ready("drive_ready");
        @(posedge clk); #1;
        bus_if.i_valid = 1'b0;
    endtask

    task automatic stream_one(input logic [8:0] s);
        bus_if.i_data  = s[7:0];
        bus_if.i_k     = s[8];
        bus_if.i_valid = 1'b1;
        wait_ready("stream_ready");
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus_if.i_data  = 8'h00;
        bus_if.i_k     = 1'b0;
        bus_if.i_valid = 1'b0;
        bus_if.i_ready = 1'b1;
`ifdef ENC8B10B_ERR_CNT_EN
        bus_if.i_cnt_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus_if.o_valid, 0);
        chk("rst_rd", bus_if.o_rd, 0);
        chk("rst_ready", bus_if.o_ready, 1);
        chk("rst_rom_rd_en", bus_if.o_rom_rd_en, 0);
        chk("rst_code", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_valid", bus_if.o_valid, 0);
        chk("idle_ready", bus_if.o_ready, 1);

        // K28.5 from RD-, checking the two-cycle latency
        drive_one(K28_5, 1'b1);
        chk("lat_accept_cycle", bus_if.o_valid, 0);
        @(posedge clk); #1;
        chk("lat_two_cycles", bus_if.o_valid, 1);
        chk("k285_rdm", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, {10'b0011111010, 2'b00});
        chk("k285_rd_pos", bus_if.o_rd, 1);

        drive_one(K28_5, 1'b1);
        @(posedge clk); #1;
        chk("k285_rdp", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, {10'b1100000101, 2'b00});
        chk("k285_rd_neg", bus_if.o_rd, 0);

        drive_one(8'hB5, 1'b0);
        @(posedge clk); #1;
        chk("d215", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, {10'b1010101010, 2'b00});
        chk("d215_rd", bus_if.o_rd, 0);

        drive_one(K28_5, 1'b1);
        @(posedge clk); #1;
        chk("to_rd_pos", bus_if.o_rd, 1);

        drive_one(8'h00, 1'b1);
        @(posedge clk); #1;
        chk("illegal_k", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, {10'b1100001011, 2'b10});
        chk("illegal_k_rd", bus_if.o_rd, 1);

        // Six ones from RD+ must flag a disparity error and leave RD alone
        drive_one(8'hFF, 1'b0);
        @(posedge clk); #1;
        chk("disp_err", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, {10'b1111110000, 2'b01});
        chk("disp_err_rd", bus_if.o_rd, 1);

        // Backpressure with continuous i_valid
        @(posedge clk); #1;
        bus_if.i_ready = 1'b0;
        stream_one(stream[0]);
        stream_one(stream[1]);
        chk("ready_drop", bus_if.o_ready, 0);
        bus_if.i_data  = stream[2][7:0];
        bus_if.i_k     = stream[2][8];
        bus_if.i_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("stall_ready", bus_if.o_ready, 0);
            chk("stall_valid", bus_if.o_valid, 1);
        end
        bus_if.i_ready = 1'b1;
        for (int i = 2; i < 6; i++) begin
            stream_one(stream[i]);
        end
        bus_if.i_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_empty", sb.size(), 0);
        chk("drain_valid", bus_if.o_valid, 0);
        chk("drain_rd", bus_if.o_rd, model_rd);

        // Reset with two symbols buffered
        bus_if.i_ready = 1'b0;
        stream_one(9'h0B5);
        stream_one(9'h1BC);
        bus_if.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", bus_if.o_valid, 1);
        chk("pre_rst_rd", bus_if.o_rd, 1);
        rst = 1'b1;
        sb.delete();
        model_rd = 1'b0;
        #1;
        chk("mid_rst_valid", bus_if.o_valid, 0);
        chk("mid_rst_rd", bus_if.o_rd, 0);
        chk("mid_rst_ready", bus_if.o_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.i_ready = 1'b1;
        drive_one(K28_5, 1'b1);
        @(posedge clk); #1;
        chk("post_rst_k285", {bus_if.o_code, bus_if.o_k_error, bus_if.o_disp_error}, {10'b0011111010, 2'b00});
        chk("post_rst_rd", bus_if.o_rd, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("final_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
